// File: rtl/ed25519_point_encode.sv
// Ed25519 point encoder: converts extended (X:Y:Z) to the 256-bit RFC 8032 encoding
// using Z^(p-2) inversion on a single bit-serial modular multiplier.
module ed25519_point_encode #(
    parameter int unsigned CYC_W = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [254:0]     P_X,
    input  logic [254:0]     P_Y,
    input  logic [254:0]     P_Z,
    output logic [255:0]     enc,
    output logic             done,
    output logic             busy,
    output logic             err,
    output logic [CYC_W-1:0] cycles
);

    localparam logic [254:0] P = 255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_EXP  = 3'd2;
    localparam logic [2:0] S_FX   = 3'd3;
    localparam logic [2:0] S_FY   = 3'd4;
    localparam logic [2:0] S_PACK = 3'd5;

    // Low five bits of the exponent p-2; bits 254..5 are all ones.
    localparam logic [4:0] E_LOW = 5'b01011;

    logic [2:0]   state;
    logic [254:0] px, py, pz, r;
    logic [254:0] acc, b_sh;
    logic [7:0]   cnt;
    logic [7:0]   bit_idx;
    logic         mul_ph;

    logic [254:0] a_op, b_op;
    logic [254:0] dbl_lo, dbl_r, acc_nxt;
    logic         dbl_ge, sum_ge;
    logic [255:0] sum;
    logic [254:0] z_can;
    logic         e_bit;

    function automatic logic [254:0] canon(input logic [254:0] v);
        return (v >= P) ? v - P : v;
    endfunction

    assign z_can = canon(pz);
    assign e_bit = (bit_idx > 8'd4) ? 1'b1 : E_LOW[bit_idx[2:0]];

    always_comb begin
        a_op = r;
        b_op = r;
        case (state)
            S_EXP:   if (mul_ph) b_op = pz;
            S_FX:    a_op = px;
            S_FY:    a_op = py;
            default: ;
        endcase
    end

    // One interleaved step: acc <- 2*acc + a*b_i mod p. The bit shifted out of a
    // 255-bit value acts as the overflow flag, so a 255-bit subtract suffices.
    always_comb begin
        dbl_lo  = {acc[253:0], 1'b0};
        dbl_ge  = acc[254] | (dbl_lo >= P);
        dbl_r   = dbl_ge ? dbl_lo - P : dbl_lo;
        sum     = {1'b0, dbl_r} + {1'b0, (b_sh[254] ? a_op : 255'd0)};
        sum_ge  = sum[255] | (sum[254:0] >= P);
        acc_nxt = sum_ge ? sum[254:0] - P : sum[254:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            px      <= '0;
            py      <= '0;
            pz      <= '0;
            r       <= '0;
            acc     <= '0;
            b_sh    <= '0;
            cnt     <= '0;
            bit_idx <= '0;
            mul_ph  <= 1'b0;
            enc     <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
            cycles  <= '0;
        end else begin
            done <= 1'b0;
            if (state != S_IDLE && cycles != {CYC_W{1'b1}}) begin
                cycles <= cycles + 1'b1;
            end
            case (state)
                S_IDLE: begin
                    // busy is still high during the done cycle, so start is ignored there.
                    if (busy) begin
                        busy <= 1'b0;
                    end else if (start) begin
                        px     <= P_X;
                        py     <= P_Y;
                        pz     <= P_Z;
                        busy   <= 1'b1;
                        err    <= 1'b0;
                        cycles <= '0;
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    px <= canon(px);
                    py <= canon(py);
                    pz <= z_can;
                    if (z_can == '0) begin
                        err   <= 1'b1;
                        state <= S_PACK;
                    end else begin
                        r       <= z_can;
                        bit_idx <= 8'd253;
                        mul_ph  <= 1'b0;
                        cnt     <= '0;
                        state   <= S_EXP;
                    end
                end
                S_EXP, S_FX, S_FY: begin
                    if (cnt == 8'd0) begin
                        acc  <= '0;
                        b_sh <= b_op;
                        cnt  <= 8'd1;
                    end else begin
                        acc  <= acc_nxt;
                        b_sh <= {b_sh[253:0], 1'b0};
                        cnt  <= cnt + 8'd1;
                        if (cnt == 8'd255) begin
                            case (state)
                                S_EXP: begin
                                    r <= acc_nxt;
                                    if (!mul_ph && e_bit) begin
                                        mul_ph <= 1'b1;
                                    end else begin
                                        mul_ph <= 1'b0;
                                        if (bit_idx == 8'd0) state <= S_FX;
                                        else bit_idx <= bit_idx - 8'd1;
                                    end
                                end
                                S_FX: begin
                                    px    <= acc_nxt;
                                    state <= S_FY;
                                end
                                default: begin
                                    py    <= acc_nxt;
                                    state <= S_PACK;
                                end
                            endcase
                        end
                    end
                end
                S_PACK: begin
                    enc   <= err ? 256'd0 : {px[0], py};
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ed25519_point_encode.sv
// Directed bench for ed25519_point_encode: known points, scaled/negated forms,
// Z = 0 paths, start robustness and mid-operation reset.
module tb_ed25519_point_encode;

    localparam int unsigned CYC_W = 18;
    localparam int NORM_LAT = 130050;

    localparam logic [255:0] PRIME = 256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;
    localparam logic [255:0] BX    = 256'h216936d3_cd6e53fe_c0a4e231_fdd6dc5c_692cc760_9525a7b2_c9562d60_8f25d51a;
    localparam logic [255:0] BY    = 256'h66666666_66666666_66666666_66666666_66666666_66666666_66666666_66666658;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [254:0]     px = '0, py = '0, pz = '0;
    logic [255:0]     enc;
    logic             done, busy, err;
    logic [CYC_W-1:0] cycles;

    int n_tests = 0;
    int n_fail = 0;
    int done_cnt = 0;

    ed25519_point_encode #(.CYC_W(CYC_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .P_X    (px),
        .P_Y    (py),
        .P_Z    (pz),
        .enc    (enc),
        .done   (done),
        .busy   (busy),
        .err    (err),
        .cycles (cycles)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // v*k mod p for small k, by repeated subtraction
    function automatic logic [254:0] mulk(input logic [255:0] v, input int unsigned k);
        logic [259:0] t;
        t = {4'd0, v} * 260'(k);
        for (int i = 0; i < 8; i++) if (t >= {4'd0, PRIME}) t = t - {4'd0, PRIME};
        return t[254:0];
    endfunction

    task automatic run_op(input string tag, input logic [254:0] x, input logic [254:0] y,
                          input logic [254:0] z, input logic hold, input int lat,
                          input logic [255:0] exp_enc, input logic exp_err);
        int edges;
        int d0;
        @(negedge clk);
        px = x;
        py = y;
        pz = z;
        start = 1'b1;
        d0 = done_cnt;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        check_eq({tag, "_busy_on"}, 256'(busy), 256'd1);
        edges = 0;
        while (!done && edges < 140000) begin
            @(posedge clk);
            edges++;
            #1;
            // re-pulse start while busy; it must be ignored
            if (hold && edges == 1000) start = 1'b0;
            if (hold && edges == 1001) start = 1'b1;
            if (hold && edges == 70000) begin
                px = '1;
                pz = '0;
            end
        end
        start = 1'b0;
        check_eq({tag, "_latency"}, 256'(edges), 256'(lat));
        check_eq({tag, "_enc"}, enc, exp_enc);
        check_eq({tag, "_err"}, 256'(err), 256'(exp_err));
        check_eq({tag, "_cycles"}, 256'(cycles), 256'(lat));
        check_eq({tag, "_busy_done"}, 256'(busy), 256'd1);
        @(posedge clk);
        #1;
        check_eq({tag, "_busy_off"}, 256'(busy), 256'd0);
        check_eq({tag, "_done_pulse"}, 256'(done), 256'd0);
        check_eq({tag, "_done_count"}, 256'(done_cnt - d0), 256'd1);
    endtask

    initial begin
        int d0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_enc", enc, 256'd0);
        check_eq("rst_done", 256'(done), 256'd0);
        check_eq("rst_busy", 256'(busy), 256'd0);
        check_eq("rst_err", 256'(err), 256'd0);
        check_eq("rst_cycles", 256'(cycles), 256'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // identity with start held high throughout
        run_op("ident", 255'd0, 255'd1, 255'd1, 1'b1, NORM_LAT, 256'd1, 1'b0);
        // started in the cycle after done: back-to-back acceptance
        run_op("base", BX[254:0], BY[254:0], 255'd1, 1'b0, NORM_LAT, BY, 1'b0);
        run_op("scale2", mulk(BX, 2), mulk(BY, 2), 255'd2, 1'b0, NORM_LAT, BY, 1'b0);
        run_op("scale7", mulk(BX, 7), mulk(BY, 7), 255'd7, 1'b0, NORM_LAT, BY, 1'b0);
        run_op("neg", 255'(PRIME - BX), BY[254:0], 255'd1, 1'b0, NORM_LAT,
               {1'b1, BY[254:0]}, 1'b0);
        run_op("z0", BX[254:0], BY[254:0], 255'd0, 1'b0, 2, 256'd0, 1'b1);
        run_op("zp", BX[254:0], BY[254:0], PRIME[254:0], 1'b0, 2, 256'd0, 1'b1);
        // leave a nonzero encoding behind so the reset check is meaningful
        run_op("base2", BX[254:0], BY[254:0], 255'd1, 1'b0, NORM_LAT, BY, 1'b0);

        @(negedge clk);
        px = 255'd0;
        py = 255'(PRIME + 256'd1);
        pz = 255'd1;
        start = 1'b1;
        d0 = done_cnt;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (59999) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_enc", enc, 256'd0);
        check_eq("midrst_done", 256'(done), 256'd0);
        check_eq("midrst_busy", 256'(busy), 256'd0);
        check_eq("midrst_err", 256'(err), 256'd0);
        check_eq("midrst_cycles", 256'(cycles), 256'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("midrst_no_done", 256'(done_cnt - d0), 256'd0);
        check_eq("midrst_idle_busy", 256'(busy), 256'd0);

        run_op("ncanon_y", 255'd0, 255'(PRIME + 256'd1), 255'd1, 1'b0, NORM_LAT, 256'd1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
